// File: rtl/fp_addsub_pipe.sv
// Three-stage pipelined floating-point adder/subtractor (align, add, normalise) with valid/ready flow control.
// Define FADDSUB_ROUND_EN for round-to-nearest-even; by default results are truncated toward zero.

module fp_addsub_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [EXP_W+MAN_W:0] a,
  input  logic [EXP_W+MAN_W:0] b,
  input  logic                 op,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [EXP_W+MAN_W:0] y,
  output logic                 ovf,
  output logic                 zero
);

  localparam int W   = EXP_W + MAN_W + 1;
  localparam int MW  = MAN_W + 4;
  localparam int LZW = $clog2(MW + 1);
  localparam int EW2 = EXP_W + 2;

  logic advance;

  logic             sa, sbEff, swap;
  logic [EXP_W-1:0] ea, eb, eA, eB, d;
  logic [MAN_W-1:0] fa, fb, fA, fB;
  logic [MW-1:0]    mBFull;
  logic             s1Sign_d, s1Sub_d;
  logic [EXP_W-1:0] s1Exp_d;
  logic [MW-1:0]    s1MA_d, s1MB_d;

  logic             s1Valid_q, s1Sign_q, s1Sub_q;
  logic [EXP_W-1:0] s1Exp_q;
  logic [MW-1:0]    s1MA_q, s1MB_q;

  logic [MW:0]      s2Sum_d;
  logic             s2Zero_d, s2Sign_d;

  logic             s2Valid_q, s2Zero_q, s2Sign_q;
  logic [EXP_W-1:0] s2Exp_q;
  logic [MW:0]      s2Sum_q;

  logic [LZW-1:0]   lz;
  logic [MW-1:0]    norm;
  logic [EW2-1:0]   expN, expR;
  logic [MAN_W+1:0] mantR;
  logic [MAN_W-1:0] frac;
  logic             roundUp;
  logic [W-1:0]     y_d;
  logic             ovf_d, zero_d;

  logic             outValid_q, ovf_q, zero_q;
  logic [W-1:0]     y_q;

  function automatic logic [LZW-1:0] lzc(input logic [MW-1:0] v);
    lzc = LZW'(MW);
    for (int i = 0; i < MW; i++) begin
      if (v[i]) lzc = LZW'(MW - 1 - i);
    end
  endfunction

  assign advance   = !outValid_q | out_ready;
  assign in_ready  = advance;
  assign out_valid = outValid_q;
  assign y         = y_q;
  assign ovf       = ovf_q;
  assign zero      = zero_q;

  // Align: order operands by magnitude (zero-exponent operands are flushed) and shift the smaller one.
  always_comb begin
    sa       = a[W-1];
    sbEff    = b[W-1] ^ op;
    ea       = a[W-2:MAN_W];
    eb       = b[W-2:MAN_W];
    fa       = (ea != '0) ? a[MAN_W-1:0] : '0;
    fb       = (eb != '0) ? b[MAN_W-1:0] : '0;
    swap     = {eb, fb} > {ea, fa};
    eA       = swap ? eb : ea;
    eB       = swap ? ea : eb;
    fA       = swap ? fb : fa;
    fB       = swap ? fa : fb;
    d        = eA - eB;
    mBFull   = {(eB != '0), fB, 3'b000};
    s1Sign_d = swap ? sbEff : sa;
    s1Sub_d  = sa ^ sbEff;
    s1Exp_d  = eA;
    s1MA_d   = {(eA != '0), fA, 3'b000};
    s1MB_d   = '0;
    if (int'(d) >= MW - 1) begin
      s1MB_d = {{(MW-1){1'b0}}, |mBFull};
    end else begin
      s1MB_d = (mBFull >> d) | {{(MW-1){1'b0}}, |(mBFull & ~({MW{1'b1}} << d))};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1Valid_q <= 1'b0;
      s1Sign_q  <= 1'b0;
      s1Sub_q   <= 1'b0;
      s1Exp_q   <= '0;
      s1MA_q    <= '0;
      s1MB_q    <= '0;
    end else if (advance) begin
      s1Valid_q <= in_valid;
      if (in_valid) begin
        s1Sign_q <= s1Sign_d;
        s1Sub_q  <= s1Sub_d;
        s1Exp_q  <= s1Exp_d;
        s1MA_q   <= s1MA_d;
        s1MB_q   <= s1MB_d;
      end
    end
  end

  // The larger operand is first, so an effective subtract never goes negative.
  always_comb begin
    s2Sum_d  = s1Sub_q ? ({1'b0, s1MA_q} - {1'b0, s1MB_q}) : ({1'b0, s1MA_q} + {1'b0, s1MB_q});
    s2Zero_d = (s2Sum_d == '0);
    s2Sign_d = s1Sign_q & !s2Zero_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2Valid_q <= 1'b0;
      s2Zero_q  <= 1'b0;
      s2Sign_q  <= 1'b0;
      s2Exp_q   <= '0;
      s2Sum_q   <= '0;
    end else if (advance) begin
      s2Valid_q <= s1Valid_q;
      if (s1Valid_q) begin
        s2Zero_q <= s2Zero_d;
        s2Sign_q <= s2Sign_d;
        s2Exp_q  <= s1Exp_q;
        s2Sum_q  <= s2Sum_d;
      end
    end
  end

  always_comb begin
    lz = lzc(s2Sum_q[MW-1:0]);
    if (s2Sum_q[MW]) begin
      norm = {s2Sum_q[MW:2], s2Sum_q[1] | s2Sum_q[0]};
      expN = {2'b00, s2Exp_q} + EW2'(1);
    end else begin
      norm = s2Sum_q[MW-1:0] << lz;
      expN = {2'b00, s2Exp_q} - {{(EW2-LZW){1'b0}}, lz};
    end
  end

`ifdef FADDSUB_ROUND_EN
  assign roundUp = norm[2] & (norm[1] | norm[0] | norm[3]);
`else
  logic [2:0] unusedGrs;
  assign roundUp   = 1'b0;
  assign unusedGrs = norm[2:0];
`endif

  // A negative or zero exponent (top bit set or all zero) flushes to +0.
  always_comb begin
    mantR = {1'b0, norm[MW-1:3]} + {{(MAN_W+1){1'b0}}, roundUp};
    if (mantR[MAN_W+1]) begin
      frac = mantR[MAN_W:1];
      expR = expN + EW2'(1);
    end else begin
      frac = mantR[MAN_W-1:0];
      expR = expN;
    end
    y_d    = {s2Sign_q, expR[EXP_W-1:0], frac};
    ovf_d  = 1'b0;
    zero_d = 1'b0;
    if (s2Zero_q || expR[EW2-1] || (expR == '0)) begin
      y_d    = '0;
      zero_d = 1'b1;
    end else if (expR >= EW2'((1 << EXP_W) - 1)) begin
      y_d   = {s2Sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outValid_q <= 1'b0;
      y_q        <= '0;
      ovf_q      <= 1'b0;
      zero_q     <= 1'b0;
    end else if (advance) begin
      outValid_q <= s2Valid_q;
      if (s2Valid_q) begin
        y_q    <= y_d;
        ovf_q  <= ovf_d;
        zero_q <= zero_d;
      end
    end
  end

endmodule

// File: tb/tb_fp_addsub_pipe.sv
// Self-checking bench for fp_addsub_pipe: exact-arithmetic reference model, scoreboard and directed vectors.
// Honours FADDSUB_ROUND_EN the same way as the design.

module tb_fp_addsub_pipe;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic        op;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready, op, out_valid, out_ready, ovf, zero;
  logic [31:0] a, b, y;

  int          total = 0;
  int          bad = 0;
  logic [33:0] expQ[$];
  vec_t        vecs[$];
  logic        holdValid = 1'b0;
  logic [33:0] holdVal;
  int          stallAccepts;

  always #5 clk = ~clk;

  fp_addsub_pipe #(.EXP_W(8), .MAN_W(23)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
    .y(y), .ovf(ovf), .zero(zero)
  );

  // Exact reference: both operands become integers on a common scale; an operand far below the
  // other only matters as a nonzero sticky contribution, so it is replaced by a single unit.
  function automatic logic [33:0] model(input logic [31:0] av, input logic [31:0] bv, input logic opv);
    logic signed [127:0] va, vb, s;
    logic [127:0] ma, mb, m, q, rem, half;
    int ea, eb, eBig, p, e;
    logic neg;
    ea   = int'(av[30:23]);
    eb   = int'(bv[30:23]);
    ma   = (ea != 0) ? {104'd0, 1'b1, av[22:0]} : 128'd0;
    mb   = (eb != 0) ? {104'd0, 1'b1, bv[22:0]} : 128'd0;
    eBig = (ea > eb) ? ea : eb;
    va   = (eBig - ea > 60) ? ((ma != 0) ? 128'sd1 : 128'sd0) : $signed(ma << (60 - (eBig - ea)));
    vb   = (eBig - eb > 60) ? ((mb != 0) ? 128'sd1 : 128'sd0) : $signed(mb << (60 - (eBig - eb)));
    if (av[31]) va = -va;
    if (bv[31] ^ opv) vb = -vb;
    s = va + vb;
    if (s == 0) return {32'h0, 1'b0, 1'b1};
    neg = (s < 0);
    m   = neg ? -s : s;
    p   = 0;
    for (int i = 0; i < 128; i++) if (m[i]) p = i;
    e = eBig + p - 83;
    if (p >= 23) begin
      q    = m >> (p - 23);
      rem  = m & ((128'd1 << (p - 23)) - 1);
      half = (p >= 24) ? (128'd1 << (p - 24)) : 128'd0;
    end else begin
      q    = m << (23 - p);
      rem  = 128'd0;
      half = 128'd0;
    end
`ifdef FADDSUB_ROUND_EN
    if (p >= 24 && (rem > half || (rem == half && q[0]))) q = q + 1;
    if (q[24]) begin
      q = q >> 1;
      e = e + 1;
    end
`endif
    if (e <= 0) return {32'h0, 1'b0, 1'b1};
    if (e >= 255) return {neg, 8'hFF, 23'h0, 1'b1, 1'b0};
    return {neg, 8'(e), q[22:0], 1'b0, 1'b0};
  endfunction

  task automatic checkOutput(input string name, input logic [33:0] got, input logic [33:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s: got y=%h ovf=%b zero=%b, want y=%h ovf=%b zero=%b",
               name, got[33:2], got[1], got[0], want[33:2], want[1], want[0]);
    end
  endtask

  task automatic checkInt(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  // Compare process: every output transfer must match the oldest expected result; stalled outputs must hold.
  always begin
    @(negedge clk);
    #2;
    if (!rst_n) begin
      holdValid = 1'b0;
    end else if (out_valid && out_ready) begin
      holdValid = 1'b0;
      if (expQ.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL unexpected_result: got y=%h with no operation outstanding", y);
      end else begin
        checkOutput("result", {y, ovf, zero}, expQ.pop_front());
      end
    end else if (out_valid) begin
      if (holdValid) checkOutput("stall_hold", {y, ovf, zero}, holdVal);
      holdValid = 1'b1;
      holdVal   = {y, ovf, zero};
    end else begin
      holdValid = 1'b0;
    end
  end

  // Streams vecs through the DUT, pulling out_ready low during cycles lo..hi, until all results drain.
  task automatic applyStimulus(input int lo, input int hi);
    int idx = 0;
    int c = 0;
    stallAccepts = -1;
    while (1) begin
      @(negedge clk);
      if (idx == vecs.size() && expQ.size() == 0) begin
        in_valid  = 1'b0;
        out_ready = 1'b1;
        break;
      end
      if (c >= 300) begin
        checkInt("stream_timeout_outstanding", expQ.size() + vecs.size() - idx, 0);
        in_valid = 1'b0;
        expQ.delete();
        break;
      end
      out_ready = !(c >= lo && c <= hi);
      if (idx < vecs.size()) begin
        in_valid = 1'b1;
        a        = vecs[idx].a;
        b        = vecs[idx].b;
        op       = vecs[idx].op;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (in_valid && !in_ready && stallAccepts < 0) stallAccepts = idx;
      if (in_valid && in_ready) begin
        expQ.push_back(model(a, b, op));
        idx++;
      end
      c++;
    end
  endtask

  task automatic measureLatency(input logic [31:0] av, input logic [31:0] bv, input logic opv);
    int n = 0;
    @(negedge clk);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    a         = av;
    b         = bv;
    op        = opv;
    #1;
    checkInt("latency_in_ready", int'(in_ready), 1);
    expQ.push_back(model(av, bv, opv));
    do begin
      @(negedge clk);
      in_valid = 1'b0;
      n++;
    end while (!out_valid && n < 10);
    checkInt("latency_cycles", n, 3);
    repeat (2) @(negedge clk);
    checkInt("latency_drained", expQ.size(), 0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a         = '0;
    b         = '0;
    op        = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_outputs", {y, ovf, zero}, 34'h0);
    checkInt("reset_out_valid", int'(out_valid), 0);
    rst_n = 1'b1;
    #1;
    checkInt("reset_in_ready", int'(in_ready), 1);

    checkOutput("pin_one_plus_one", model(32'h3F800000, 32'h3F800000, 1'b0), {32'h40000000, 2'b00});
    checkOutput("pin_three_minus_one", model(32'h40400000, 32'h3F800000, 1'b1), {32'h40000000, 2'b00});
    checkOutput("pin_cancel", model(32'h3F800000, 32'h3F800000, 1'b1), {32'h00000000, 2'b01});
    checkOutput("pin_overflow", model(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0), {32'h7F800000, 2'b10});
    checkOutput("pin_underflow", model(32'h00800000, 32'h00800001, 1'b1), {32'h00000000, 2'b01});
    checkOutput("pin_neg_result", model(32'hC0A00000, 32'h40400000, 1'b0), {32'hC0000000, 2'b00});
    checkOutput("pin_zero_minus", model(32'h00000000, 32'h3F800000, 1'b1), {32'hBF800000, 2'b00});
`ifdef FADDSUB_ROUND_EN
    checkOutput("pin_round", model(32'h4B800000, 32'h3FC00000, 1'b0), {32'h4B800001, 2'b00});
    checkOutput("pin_sticky", model(32'h3F800000, 32'h0C000000, 1'b1), {32'h3F800000, 2'b00});
`else
    checkOutput("pin_round", model(32'h4B800000, 32'h3FC00000, 1'b0), {32'h4B800000, 2'b00});
    checkOutput("pin_sticky", model(32'h3F800000, 32'h0C000000, 1'b1), {32'h3F7FFFFF, 2'b00});
`endif

    measureLatency(32'h3F800000, 32'h3F800000, 1'b0);

    vecs = '{
      '{32'h40400000, 32'h3F800000, 1'b1}, '{32'h3F800000, 32'h3F800000, 1'b1},
      '{32'h4B800000, 32'h3FC00000, 1'b0}, '{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0},
      '{32'h00800000, 32'h00800001, 1'b1}, '{32'hC0A00000, 32'h40400000, 1'b0},
      '{32'h3F800000, 32'h00000000, 1'b0}, '{32'h40000000, 32'hC0000000, 1'b1},
      '{32'h3F800000, 32'h33800000, 1'b1}, '{32'h00000000, 32'h3F800000, 1'b1},
      '{32'h3F800000, 32'h34000000, 1'b0}, '{32'h3F800000, 32'h0C000000, 1'b0},
      '{32'h3F800000, 32'h0C000000, 1'b1}, '{32'hBF800000, 32'h3F800000, 1'b0}
    };
    applyStimulus(-1, -2);

    vecs = '{
      '{32'h3F800000, 32'h3F800000, 1'b0}, '{32'h40400000, 32'h3F800000, 1'b1},
      '{32'hC0A00000, 32'h40400000, 1'b0}, '{32'h4B800000, 32'h3FC00000, 1'b0},
      '{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0}, '{32'h3F800000, 32'h33800000, 1'b1}
    };
    applyStimulus(2, 7);
    checkInt("stall_accepts_before_in_ready_low", stallAccepts, 3);

    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      in_valid = 1'b1;
      a        = 32'h40400000 + 32'(k);
      b        = 32'h3F800000;
      op       = 1'b0;
      #1;
      if (in_ready) expQ.push_back(model(a, b, op));
    end
    @(negedge clk);
    rst_n    = 1'b0;
    in_valid = 1'b0;
    #1;
    checkInt("midreset_out_valid", int'(out_valid), 0);
    checkOutput("midreset_outputs", {y, ovf, zero}, 34'h0);
    expQ.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    checkInt("postreset_no_stale", int'(out_valid), 0);
    measureLatency(32'hC0A00000, 32'h40400000, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
